// File: rtl/core_pkg.sv
// Shared core types and helpers for the fetch/decode boundary.
package core_pkg;

   typedef struct packed {
      logic [31:0] istr;
      logic [31:0] pc;
      logic        is_c;
   } istr_entry_t;

   function automatic logic is_compressed(input logic [31:0] istr);
      return istr[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/core_istr_fifo.sv
// Instruction queue between fetch and decode; one-cycle latency, no bypass, one-cycle flush.
// in_ready = !full from registered count only, so decode stalls never reach fetch combinationally.
module core_istr_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             flush_en,
   input  logic [31:0]      in_istr,
   input  logic [31:0]      in_pc,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      out_istr,
   output logic [31:0]      out_pc,
   output logic             out_is_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   istr_entry_t      mem [DEPTH];
   istr_entry_t      head;
   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] rp;
   logic             push;
   logic             pop;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush_en;
   assign pop       = out_valid && out_ready && !flush_en;

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush_en) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= '{istr: in_istr, pc: in_pc, is_c: is_compressed(in_istr)};
      end
   end

   assign head     = mem[rp];
   assign out_istr = out_valid ? head.istr : '0;
   assign out_pc   = out_valid ? head.pc   : '0;
   assign out_is_c = out_valid ? head.is_c : 1'b0;

endmodule

// File: tb/tb_core_istr_fifo.sv
// Directed plus random bench for core_istr_fifo against a queue-based reference model.
module tb_core_istr_fifo;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rest = 1'b1;
   logic             flush_en = 1'b0;
   logic [31:0]      in_istr = '0;
   logic [31:0]      in_pc = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      out_istr;
   logic [31:0]      out_pc;
   logic             out_is_c;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] count;

   int errors = 0;
   int checks = 0;

   logic [63:0] model_q[$];

   core_istr_fifo #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rest      (rest),
      .flush_en  (flush_en),
      .in_istr   (in_istr),
      .in_pc     (in_pc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_istr  (out_istr),
      .out_pc    (out_pc),
      .out_is_c  (out_is_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic        v;
      logic [31:0] ei;
      logic [31:0] ep;
      v  = (model_q.size() != 0);
      ei = v ? model_q[0][63:32] : 32'h0;
      ep = v ? model_q[0][31:0]  : 32'h0;
      chk({tag, ".count"},     32'(count),     32'(model_q.size()));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".in_ready"},  32'(in_ready),  32'(model_q.size() != DEPTH));
      chk({tag, ".out_istr"},  out_istr,       ei);
      chk({tag, ".out_pc"},    out_pc,         ep);
      chk({tag, ".out_is_c"},  32'(out_is_c),  32'(v && (ei[1:0] != 2'b11)));
   endtask

   // Drive one cycle's inputs at the falling edge, update the model at the rising edge, check just after.
   task automatic cycle(input logic iv, input logic [31:0] istr, input logic [31:0] pc,
                        input logic ordy, input logic fl, input string tag);
      bit do_push;
      bit do_pop;
      @(negedge clk);
      in_valid  = iv;
      in_istr   = istr;
      in_pc     = pc;
      out_ready = ordy;
      flush_en  = fl;
      do_push = iv && (model_q.size() < DEPTH) && !fl;
      do_pop  = ordy && (model_q.size() > 0) && !fl;
      @(posedge clk);
      if (fl) model_q.delete();
      else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({istr, pc});
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      #2;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready",  32'(in_ready),  32'd1);
      chk("rst.count",     32'(count),     32'd0);
      chk("rst.out_istr",  out_istr,       32'd0);
      chk("rst.out_pc",    out_pc,         32'd0);
      chk("rst.out_is_c",  32'(out_is_c),  32'd0);
      @(negedge clk);
      rest = 1'b0;

      // First push visible the following cycle
      cycle(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0, "first");
      chk("first.istr", out_istr, 32'h13);
      chk("first.is_c", 32'(out_is_c), 32'd0);
      chk("first.count", 32'(count), 32'd1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain0");

      // Fill and drain
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000_0013 + 32'(i << 8), 32'(i * 4), 1'b0, 1'b0, "fill");
      chk("full.in_ready", 32'(in_ready), 32'd0);
      chk("full.count", 32'(count), 32'd4);
      cycle(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0, "fifth");
      chk("fifth.count", 32'(count), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk("drain.order", out_pc, 32'(i * 4));
         cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
      end
      chk("drain.empty", 32'(out_valid), 32'd0);

      // Concurrent push/pop at full, then sustained streaming across wraps
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0000_1003, 32'h100 + 32'(i * 4), 1'b0, 1'b0, "refill");
      cycle(1'b1, 32'h0000_2003, 32'h200, 1'b1, 1'b0, "fullpp");
      chk("fullpp.count", 32'(count), 32'd3);
      for (int i = 0; i < 44; i++) begin
         cycle(1'b1, $urandom, 32'h300 + 32'(i * 4), 1'b1, 1'b0, "stream");
         chk("stream.count", 32'(count), 32'd3);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain2");

      // Compressed tagging
      cycle(1'b1, 32'h0000_4501, 32'h42, 1'b0, 1'b0, "cmp");
      chk("cmp.is_c", 32'(out_is_c), 32'd1);
      chk("cmp.istr16", 32'(out_istr[15:0]), 32'h4501);
      chk("cmp.pc", out_pc, 32'h42);

      // Flush drops the offered instruction
      cycle(1'b1, 32'h0000_0033, 32'h44, 1'b0, 1'b0, "pf1");
      cycle(1'b1, 32'h0000_0033, 32'h48, 1'b0, 1'b0, "pf2");
      chk("preflush.count", 32'(count), 32'd3);
      cycle(1'b1, 32'h0000_0013, 32'h8b0, 1'b0, 1'b1, "flush");
      chk("flush.count", 32'(count), 32'd0);
      chk("flush.valid", 32'(out_valid), 32'd0);
      cycle(1'b1, 32'h0000_0013, 32'h8b0, 1'b0, 1'b0, "postflush");
      chk("postflush.count", 32'(count), 32'd1);
      chk("postflush.pc", out_pc, 32'h8b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 31) == 0), "rand");
      end

      // Asynchronous reset mid-stream
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "prereset_flush");
      cycle(1'b1, 32'h0000_0003, 32'h500, 1'b0, 1'b0, "ar1");
      cycle(1'b1, 32'h0000_0007, 32'h504, 1'b0, 1'b0, "ar2");
      chk("ar.count", 32'(count), 32'd2);
      in_valid = 1'b0;
      #2;
      rest = 1'b1;
      #1;
      model_q.delete();
      check_all("areset");
      chk("areset.in_ready", 32'(in_ready), 32'd1);
      #1;
      rest = 1'b0;
      cycle(1'b1, 32'h0000_0017, 32'h600, 1'b0, 1'b0, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
